stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 173 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Sequences N_STAGES handshaked stages (start -> done -> ack -> done low),
// with a per-stage watchdog, a latched error cause and a saturating pass counter.
module stage_sequencer #(
   parameter int N_STAGES  = 2,
   parameter int TIMEOUT_W = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 mode_loop,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   input  logic                 err_clear,
   input  logic [N_STAGES-1:0]  stage_done,
   input  logic [N_STAGES-1:0]  stage_error,
   output logic [N_STAGES-1:0]  stage_start,
   output logic [N_STAGES-1:0]  stage_ack,
   output logic [2:0]           cur_stage,
   output logic [2:0]           state,
   output logic                 busy,
   output logic                 err_flag,
   output logic [2:0]           err_stage,
   output logic [1:0]           err_code,
   output logic [15:0]          pass_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_EXEC  = 3'd2,
      S_DONE  = 3'd3,
      S_ACK   = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   state_t               fsm_q, fsm_d;
   logic [2:0]           stage_q, stage_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic [TIMEOUT_W-1:0] limit_q, limit_d;
   logic [2:0]           err_stage_q, err_stage_d;
   logic [1:0]           err_code_q, err_code_d;
   logic [15:0]          pass_q, pass_d;

   logic                 done_cur;
   logic                 error_cur;
   logic                 stage_last;
   logic                 wd_expired;
   logic [N_STAGES-1:0]  stage_sel;

   // Only the active stage's done/error bits are ever looked at.
   always_comb begin
      done_cur  = 1'b0;
      error_cur = 1'b0;
      stage_sel = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         if (stage_q == 3'(i)) begin
            done_cur     = stage_done[i];
            error_cur    = stage_error[i];
            stage_sel[i] = 1'b1;
         end
      end
   end

   assign stage_last = (stage_q == 3'(N_STAGES - 1));
   // The watchdog stops at limit-1, so it cannot wrap while a limit is armed.
   assign wd_expired = (limit_q != '0) && (wd_q == limit_q - 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q       <= S_IDLE;
         stage_q     <= '0;
         wd_q        <= '0;
         limit_q     <= '0;
         err_stage_q <= '0;
         err_code_q  <= '0;
         pass_q      <= '0;
      end else begin
         fsm_q       <= fsm_d;
         stage_q     <= stage_d;
         wd_q        <= wd_d;
         limit_q     <= limit_d;
         err_stage_q <= err_stage_d;
         err_code_q  <= err_code_d;
         pass_q      <= pass_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      stage_d     = stage_q;
      wd_d        = wd_q;
      limit_d     = limit_q;
      err_stage_d = err_stage_q;
      err_code_d  = err_code_q;
      pass_d      = pass_q;
      case (fsm_q)
         S_IDLE: begin
            stage_d = '0;
            if (enable) fsm_d = S_START;
         end
         S_START: begin
            limit_d = timeout_cycles;
            wd_d    = '0;
            fsm_d   = S_EXEC;
         end
         S_EXEC: begin
            if (error_cur) begin
               fsm_d       = S_ERROR;
               err_code_d  = 2'b01;
               err_stage_d = stage_q;
            end else if (done_cur) begin
               fsm_d = S_DONE;
            end else if (wd_expired) begin
               fsm_d       = S_ERROR;
               err_code_d  = 2'b10;
               err_stage_d = stage_q;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_DONE: begin
            wd_d  = '0;
            fsm_d = S_ACK;
         end
         S_ACK: begin
            // Completion (done seen low) takes priority over a same-cycle expiry.
            if (!done_cur) begin
               if (stage_last) begin
                  if (pass_q != 16'hFFFF) pass_d = pass_q + 1'b1;
                  stage_d = '0;
                  fsm_d   = (mode_loop && enable) ? S_START : S_IDLE;
               end else if (enable) begin
                  stage_d = stage_q + 3'd1;
                  fsm_d   = S_START;
               end else begin
                  stage_d = '0;
                  fsm_d   = S_IDLE;
               end
            end else if (wd_expired) begin
               fsm_d       = S_ERROR;
               err_code_d  = 2'b11;
               err_stage_d = stage_q;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_ERROR: begin
            if (err_clear) begin
               fsm_d       = S_IDLE;
               stage_d     = '0;
               err_stage_d = '0;
               err_code_d  = '0;
            end
         end
         default: begin
            fsm_d       = S_ERROR;
            err_code_d  = 2'b00;
            err_stage_d = stage_q;
         end
      endcase
   end

   assign stage_start = (fsm_q == S_START || fsm_q == S_EXEC) ? stage_sel : '0;
   assign stage_ack   = (fsm_q == S_ACK) ? stage_sel : '0;
   assign cur_stage   = stage_q;
   assign state       = fsm_q;
   assign busy        = (fsm_q == S_START) || (fsm_q == S_EXEC) ||
                        (fsm_q == S_DONE)  || (fsm_q == S_ACK);
   assign err_flag    = (fsm_q == S_ERROR);
   assign err_stage   = err_stage_q;
   assign err_code    = err_code_q;
   assign pass_count  = pass_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: each stage's timeline is predicted arithmetically
// from its done/error/release delays and the watchdog limit, then compared cycle by cycle.
module tb_stage_sequencer;

   localparam int N     = 2;
   localparam int TW    = 24;
   localparam int NEVER = 1000;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          mode_loop;
   logic [TW-1:0] timeout_cycles;
   logic          err_clear;
   logic [N-1:0]  stage_done;
   logic [N-1:0]  stage_error;
   logic [N-1:0]  stage_start;
   logic [N-1:0]  stage_ack;
   logic [2:0]    cur_stage;
   logic [2:0]    state;
   logic          busy;
   logic          err_flag;
   logic [2:0]    err_stage;
   logic [1:0]    err_code;
   logic [15:0]   pass_count;

   int total    = 0;
   int bad      = 0;
   int exp_pass = 0;

   always #5 clk = ~clk;

   stage_sequencer #(.N_STAGES(N), .TIMEOUT_W(TW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode_loop(mode_loop),
      .timeout_cycles(timeout_cycles), .err_clear(err_clear),
      .stage_done(stage_done), .stage_error(stage_error),
      .stage_start(stage_start), .stage_ack(stage_ack), .cur_stage(cur_stage),
      .state(state), .busy(busy), .err_flag(err_flag), .err_stage(err_stage),
      .err_code(err_code), .pass_count(pass_count)
   );

   // Plays the stage block for one stage, starting at the negedge where START is visible.
   // d: cycles from START until done rises; r: cycles done stays high after ack appears;
   // e: cycle error rises. Returns 0 on completion, the error code on ERROR, 4 on abort.
   task automatic drive_stage(input int idx, input int d, input int r, input int e,
                              input int lim, input int others, input int abort_at,
                              input int en_drop_at, output int res);
      int exec_t, kind, a, fin;
      logic [N-1:0]  oh, od, oe;
      logic [11:0]   obs, expv;
      logic [2:0]    est;
      logic [15:0]   eobs, eexp;
      oh = '0;
      oh[idx] = 1'b1;
      exec_t = NEVER; kind = 0;
      if (e < exec_t) begin exec_t = e; kind = 1; end
      if (d < exec_t) begin exec_t = d; kind = 2; end
      if (lim != 0 && lim < exec_t) begin exec_t = lim; kind = 3; end
      a = exec_t + 2;
      res = 0;
      if (kind == 1) begin fin = exec_t + 1; res = 1; end
      else if (kind == 3) begin fin = exec_t + 1; res = 2; end
      else if (lim != 0 && r + 1 > lim) begin fin = a + lim; res = 3; end
      else fin = a + r + 1;
      for (int c = 0; c <= fin; c++) begin
         if (c == fin) begin
            if (res != 0) begin
               eobs = {state, stage_start, stage_ack, busy, err_flag, err_stage, err_code, 1'b0};
               eexp = {3'd5, 2'b00, 2'b00, 1'b0, 1'b1, 3'(idx), 2'(res), 1'b0};
               total++;
               if (eobs !== eexp) begin
                  bad++;
                  $display("[TB] FAIL error_entry stage%0d: got %h want %h", idx, eobs, eexp);
               end
            end
            return;
         end
         if (c == 0)           begin est = 3'd1; expv = {est, 3'(idx), oh, 2'b00, 2'b10}; end
         else if (c <= exec_t) begin est = 3'd2; expv = {est, 3'(idx), oh, 2'b00, 2'b10}; end
         else if (c == exec_t + 1) begin est = 3'd3; expv = {est, 3'(idx), 2'b00, 2'b00, 2'b10}; end
         else                  begin est = 3'd4; expv = {est, 3'(idx), 2'b00, oh, 2'b10}; end
         obs = {state, cur_stage, stage_start, stage_ack, busy, err_flag};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL stage%0d_cycle%0d: got %h want %h", idx, c, obs, expv);
         end
         if (c == abort_at) begin
            res = 4;
            return;
         end
         timeout_cycles = (c == 0) ? TW'(lim) : TW'($urandom);
         case (others)
            0:       begin od = '0; oe = '0; end
            1:       begin od = N'($urandom); oe = N'($urandom); end
            default: begin od = '1; oe = '1; end
         endcase
         od[idx] = (c >= d) && (kind != 2 || c < a + r);
         oe[idx] = (c >= e);
         stage_done  = od;
         stage_error = oe;
         if (c == en_drop_at) enable = 1'b0;
         @(negedge clk);
      end
   endtask

   // Checks where the sequencer goes after a stage's handshake completes.
   task automatic finish_stage(input int idx, output int nxt);
      logic [21:0] obs, expv;
      if (idx < N - 1) begin
         nxt = enable ? idx + 1 : -1;
      end else begin
         if (exp_pass < 65535) exp_pass++;
         nxt = (mode_loop && enable) ? 0 : -1;
      end
      expv = {(nxt < 0) ? 3'd0 : 3'd1, (nxt < 0) ? 3'd0 : 3'(nxt), 16'(exp_pass)};
      obs  = {state, cur_stage, pass_count};
      total++;
      if (obs !== expv) begin
         bad++;
         $display("[TB] FAIL after_stage%0d: got %h want %h", idx, obs, expv);
      end
      if (nxt < 0) enable = 1'b0;
   endtask

   task automatic clear_error(input int idx, input int code);
      logic [13:0] obs, expv;
      enable = 1'b0;
      stage_done = '0;
      stage_error = '0;
      repeat (2) begin
         @(negedge clk);
         obs  = {state, stage_start, stage_ack, busy, err_flag, err_stage, err_code};
         expv = {3'd5, 2'b00, 2'b00, 1'b0, 1'b1, 3'(idx), 2'(code)};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL error_hold: got %h want %h", obs, expv);
         end
      end
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      obs  = {state, cur_stage, 2'b00, busy, err_flag, err_stage, err_code};
      expv = 14'd0;
      total++;
      if (obs !== expv) begin
         bad++;
         $display("[TB] FAIL error_clear: got %h want %h", obs, expv);
      end
   endtask

   task automatic start_from_idle();
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      err_clear = 1'b0;
      stage_done = '0;
      stage_error = '0;
      @(negedge clk);
      reset = 1'b0;
      exp_pass = 0;
   endtask

   function automatic logic [32:0] all_outputs();
      return {state, cur_stage, stage_start, stage_ack, busy, err_flag,
              err_stage, err_code, pass_count};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b0;
      mode_loop = 1'b0;
      err_clear = 1'b0;
      timeout_cycles = '0;
      stage_done = '0;
      stage_error = '0;
      #1;
      total++;
      if (all_outputs() !== 33'd0) begin
         bad++;
         $display("[TB] FAIL reset_values: got %h want 0", all_outputs());
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (all_outputs() !== 33'd0) begin
         bad++;
         $display("[TB] FAIL idle_after_reset: got %h want 0", all_outputs());
      end
   endtask

   task automatic test_single_pass();
      int res, nxt;
      mode_loop = 1'b0;
      start_from_idle();
      drive_stage(0, 3, 1, NEVER, 0, 0, -1, -1, res);
      finish_stage(0, nxt);
      drive_stage(1, 3, 1, NEVER, 0, 0, -1, -1, res);
      finish_stage(1, nxt);
   endtask

   task automatic test_loop();
      int res, nxt;
      do_reset();
      mode_loop = 1'b1;
      start_from_idle();
      for (int p = 0; p < 3; p++) begin
         drive_stage(0, 2, 1, NEVER, 0, 1, -1, -1, res);
         finish_stage(0, nxt);
         drive_stage(1, 3, 2, NEVER, 0, 1, -1, -1, res);
         finish_stage(1, nxt);
      end
      drive_stage(0, 3, 1, NEVER, 0, 1, -1, -1, res);
      finish_stage(0, nxt);
      drive_stage(1, 4, 1, NEVER, 0, 1, -1, 2, res);
      finish_stage(1, nxt);
      repeat (3) begin
         @(negedge clk);
         total++;
         if ({state, stage_start} !== 5'd0) begin
            bad++;
            $display("[TB] FAIL loop_stays_idle: got %h want 0", {state, stage_start});
         end
      end
      mode_loop = 1'b0;
   endtask

   task automatic test_exec_timeout();
      int res;
      start_from_idle();
      drive_stage(0, NEVER, 0, NEVER, 10, 0, -1, -1, res);
      clear_error(0, 2);
   endtask

   task automatic test_ack_timeout();
      int res, nxt;
      start_from_idle();
      drive_stage(0, 3, 1, NEVER, 5, 0, -1, -1, res);
      finish_stage(0, nxt);
      drive_stage(1, 3, NEVER, NEVER, 5, 0, -1, -1, res);
      clear_error(1, 3);
   endtask

   task automatic test_error_priority();
      int res, nxt;
      start_from_idle();
      drive_stage(0, 2, 1, NEVER, 0, 2, -1, -1, res);
      finish_stage(0, nxt);
      drive_stage(1, 2, 0, NEVER, 0, 0, -1, -1, res);
      finish_stage(1, nxt);
      start_from_idle();
      drive_stage(0, 3, 1, 3, 0, 0, -1, -1, res);
      clear_error(0, 1);
   endtask

   task automatic test_reset_mid_ack();
      int res, nxt;
      start_from_idle();
      drive_stage(0, 2, 1, NEVER, 0, 0, -1, -1, res);
      finish_stage(0, nxt);
      drive_stage(1, 3, 4, NEVER, 0, 0, 6, -1, res);
      #2 reset = 1'b1;
      #1;
      total++;
      if (all_outputs() !== 33'd0) begin
         bad++;
         $display("[TB] FAIL async_reset_mid_ack: got %h want 0", all_outputs());
      end
      exp_pass = 0;
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      total++;
      if ({state, cur_stage, stage_ack, pass_count} !== {3'd1, 3'd0, 2'b00, 16'd0}) begin
         bad++;
         $display("[TB] FAIL resume_after_reset: got %h want %h",
                  {state, cur_stage, stage_ack, pass_count}, {3'd1, 3'd0, 2'b00, 16'd0});
      end
      drive_stage(0, 2, 0, NEVER, 0, 0, -1, 0, res);
      finish_stage(0, nxt);
   endtask

   task automatic test_random();
      int res, nxt, idx, d, r, e, lim;
      start_from_idle();
      nxt = 0;
      for (int k = 0; k < 40; k++) begin
         idx = nxt;
         enable    = ($urandom_range(0, 3) != 0);
         mode_loop = 1'($urandom_range(0, 1));
         d   = int'($urandom_range(1, 5));
         r   = int'($urandom_range(0, 3));
         e   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, d)) : NEVER;
         lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 8));
         drive_stage(idx, d, r, e, lim, 1, -1, -1, res);
         if (res != 0) begin
            clear_error(idx, res);
            start_from_idle();
            nxt = 0;
         end else begin
            finish_stage(idx, nxt);
            if (nxt < 0) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               start_from_idle();
               nxt = 0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_loop();
      test_exec_timeout();
      test_ack_timeout();
      test_error_priority();
      test_reset_mid_ack();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
